// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_pkg
// Purpose  : Shared definitions for the ID/EX pipeline boundary. Holds the
//            control-bundle bit map, the register-address type and the
//            bubble encoding.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package pipe_pkg;
  localparam int CTRL_W         = 10;
  localparam int REG_ADDR_W     = 5;

  // Control bundle bit positions produced by the main decoder.
  localparam int CTRL_REGWRITE  = 0;
  localparam int CTRL_MEMTOREG  = 1;
  localparam int CTRL_MEMREAD   = 2;
  localparam int CTRL_MEMWRITE  = 3;
  localparam int CTRL_ALUSRC    = 4;
  localparam int CTRL_REGDST    = 5;
  localparam int CTRL_BRANCH    = 6;
  localparam int CTRL_ALUOP_LSB = 7;
  localparam int CTRL_ALUOP_MSB = 9;

  typedef logic [CTRL_W-1:0]     ctrl_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  // All-zero control: no register write, no memory access, no branch.
  localparam ctrl_t CTRL_BUBBLE = 10'b0;
endpackage
`default_nettype wire

// File: rtl/id_ex_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage_if
// Purpose  : Bundle of the decode-side inputs and execute-side outputs of the
//            ID/EX boundary.
// Ports    : master - decode/execute environment: drives ID_*, EX_flush;
//                     observes PC_Write, IF_ID_Write, EX_*, counters
//            slave  - the ID/EX stage itself (mirror of master)
// Revision : 1.0 - initial release
// ============================================================================
interface id_ex_stage_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  import pipe_pkg::*;

  reg_addr_t         ID_Rs_addr;
  reg_addr_t         ID_Rt_addr;
  reg_addr_t         ID_Rd_addr;
  logic              ID_uses_rt;
  ctrl_t             ID_ctrl;
  logic [DATA_W-1:0] ID_RS_data;
  logic [DATA_W-1:0] ID_RT_data;
  logic [DATA_W-1:0] ID_imm;
  logic [DATA_W-1:0] ID_pc4;
  logic              EX_flush;

  logic              PC_Write;
  logic              IF_ID_Write;
  reg_addr_t         EX_Rs_addr;
  reg_addr_t         EX_Rt_addr;
  reg_addr_t         EX_Rd_addr;
  ctrl_t             EX_ctrl;
  logic [DATA_W-1:0] EX_RS_data;
  logic [DATA_W-1:0] EX_RT_data;
  logic [DATA_W-1:0] EX_imm;
  logic [DATA_W-1:0] EX_pc4;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  modport master (
    output ID_Rs_addr, ID_Rt_addr, ID_Rd_addr, ID_uses_rt, ID_ctrl,
           ID_RS_data, ID_RT_data, ID_imm, ID_pc4, EX_flush,
    input  PC_Write, IF_ID_Write, EX_Rs_addr, EX_Rt_addr, EX_Rd_addr,
           EX_ctrl, EX_RS_data, EX_RT_data, EX_imm, EX_pc4,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  ID_Rs_addr, ID_Rt_addr, ID_Rd_addr, ID_uses_rt, ID_ctrl,
           ID_RS_data, ID_RT_data, ID_imm, ID_pc4, EX_flush,
    output PC_Write, IF_ID_Write, EX_Rs_addr, EX_Rt_addr, EX_Rd_addr,
           EX_ctrl, EX_RS_data, EX_RT_data, EX_imm, EX_pc4,
           stall_cnt, flush_cnt
  );
endinterface
`default_nettype wire

// File: rtl/id_ex_stage_load_use_detect.sv
`default_nettype none
// ============================================================================
// Module   : load_use_detect
// Purpose  : Combinational load-use hazard detector. Flags when the load now
//            in EX writes a register that the instruction in ID reads.
// Ports    : i_ex_memread  - EX instruction is a load
//            i_ex_rt       - load destination (Rt of the EX instruction)
//            i_id_rs       - ID source register Rs
//            i_id_rt       - ID register field Rt
//            i_id_uses_rt  - ID instruction actually reads Rt
//            o_hazard      - load-use hazard present
// Revision : 1.0 - initial release
// ============================================================================
module load_use_detect
  import pipe_pkg::*;
(
  input  logic      i_ex_memread,
  input  reg_addr_t i_ex_rt,
  input  reg_addr_t i_id_rs,
  input  reg_addr_t i_id_rt,
  input  logic      i_id_uses_rt,
  output logic      o_hazard
);
  logic w_rs_match;
  logic w_rt_match;

  assign w_rs_match = (i_ex_rt == i_id_rs);
  // Rt only matters when it is a source (R-type, beq, sw), not a destination.
  assign w_rt_match = i_id_uses_rt && (i_ex_rt == i_id_rt);
  // A load into $0 produces nothing to wait for.
  assign o_hazard   = i_ex_memread && (i_ex_rt != '0) && (w_rs_match || w_rt_match);
endmodule
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage
// Purpose  : ID/EX pipeline register with load-use stall generation, branch
//            flush bubbles and saturating stall/flush event counters.
// Ports    : clk_i  - clock, all state on rising edge
//            rst_i  - synchronous active-high reset
//            bus    - id_ex_stage_if.slave: ID_* / EX_flush in;
//                     PC_Write, IF_ID_Write, EX_*, stall_cnt, flush_cnt out
// Revision : 1.0 - initial release
// ============================================================================
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
)(
  input  logic          clk_i,
  input  logic          rst_i,
  id_ex_stage_if.slave  bus
);
  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  reg_addr_t         r_ex_rs;
  reg_addr_t         r_ex_rt;
  reg_addr_t         r_ex_rd;
  ctrl_t             r_ex_ctrl;
  logic [DATA_W-1:0] r_ex_rs_data;
  logic [DATA_W-1:0] r_ex_rt_data;
  logic [DATA_W-1:0] r_ex_imm;
  logic [DATA_W-1:0] r_ex_pc4;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;

  logic w_load_use;
  logic w_stall;
  logic w_bubble;

  load_use_detect u_load_use_detect (
    .i_ex_memread (r_ex_ctrl[CTRL_MEMREAD]),
    .i_ex_rt      (r_ex_rt),
    .i_id_rs      (bus.ID_Rs_addr),
    .i_id_rt      (bus.ID_Rt_addr),
    .i_id_uses_rt (bus.ID_uses_rt),
    .o_hazard     (w_load_use)
  );

  // A taken branch squashes the dependent instruction anyway, so the PC must
  // keep moving to fetch the target rather than hold for the load.
  assign w_stall  = w_load_use && !bus.EX_flush;
  assign w_bubble = bus.EX_flush || w_load_use;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ex_rs      <= '0;
      r_ex_rt      <= '0;
      r_ex_rd      <= '0;
      r_ex_ctrl    <= CTRL_BUBBLE;
      r_ex_rs_data <= '0;
      r_ex_rt_data <= '0;
      r_ex_imm     <= '0;
      r_ex_pc4     <= '0;
      r_stall_cnt  <= '0;
      r_flush_cnt  <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != C_CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + C_CNT_ONE;
      end
      if (bus.EX_flush && (r_flush_cnt != C_CNT_MAX)) begin
        r_flush_cnt <= r_flush_cnt + C_CNT_ONE;
      end

      // The bubble clears MemRead, so a stall can never extend past one cycle.
      if (w_bubble) begin
        r_ex_rs      <= '0;
        r_ex_rt      <= '0;
        r_ex_rd      <= '0;
        r_ex_ctrl    <= CTRL_BUBBLE;
        r_ex_rs_data <= '0;
        r_ex_rt_data <= '0;
        r_ex_imm     <= '0;
        r_ex_pc4     <= '0;
      end else begin
        r_ex_rs      <= bus.ID_Rs_addr;
        r_ex_rt      <= bus.ID_Rt_addr;
        r_ex_rd      <= bus.ID_Rd_addr;
        r_ex_ctrl    <= bus.ID_ctrl;
        r_ex_rs_data <= bus.ID_RS_data;
        r_ex_rt_data <= bus.ID_RT_data;
        r_ex_imm     <= bus.ID_imm;
        r_ex_pc4     <= bus.ID_pc4;
      end
    end
  end

  assign bus.PC_Write    = !w_stall;
  assign bus.IF_ID_Write = !w_stall;
  assign bus.EX_Rs_addr  = r_ex_rs;
  assign bus.EX_Rt_addr  = r_ex_rt;
  assign bus.EX_Rd_addr  = r_ex_rd;
  assign bus.EX_ctrl     = r_ex_ctrl;
  assign bus.EX_RS_data  = r_ex_rs_data;
  assign bus.EX_RT_data  = r_ex_rt_data;
  assign bus.EX_imm      = r_ex_imm;
  assign bus.EX_pc4      = r_ex_pc4;
  assign bus.stall_cnt   = r_stall_cnt;
  assign bus.flush_cnt   = r_flush_cnt;
endmodule
`default_nettype wire
